// File: rtl/data_mem_unit.sv
// Byte-addressable data memory unit: single-request IDLE/ACCESS/RESP handshake FSM.
// Optional macro DMU_ALIGN_CHECK_EN rejects misaligned accesses instead of aligning them down.
module data_mem_unit #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              wb_en,
  output logic [4:0]        wb_rd
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LB     = $clog2(NBYTES);
  localparam int IDX_W  = ADDR_W - LB;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Access width in bytes, clamped to the word width.
  function automatic logic [LB:0] size_bytes(input logic [1:0] sz);
    int b;
    b = 1 << sz;
    if (b > NBYTES) b = NBYTES;
    return (LB + 1)'(b);
  endfunction

  function automatic logic [NBYTES-1:0] lane_mask(input logic [LB:0] nb);
    logic [NBYTES-1:0] m;
    for (int k = 0; k < NBYTES; k++) m[k] = (k < int'(nb));
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [LB:0] nb,
                                               input logic sext);
    logic [DATA_W-1:0] r;
    logic msb;
    msb = 1'b0;
    for (int k = 0; k < NBYTES; k++)
      if (k == int'(nb) - 1) msb = v[8*k+7];
    for (int k = 0; k < NBYTES; k++)
      r[8*k +: 8] = (k < int'(nb)) ? v[8*k +: 8] : {8{sext & msb}};
    return r;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_wb_en;
  logic [4:0]        r_wb_rd;

  logic [LB:0]       w_nbytes;
  logic [LB-1:0]     w_lane_off;
  logic [LB-1:0]     w_low_mask;
  logic [LB-1:0]     w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic [NBYTES-1:0] w_bmask;
  logic [DATA_W-1:0] w_wshift;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_load;

  always_comb begin
    w_nbytes   = size_bytes(r_size);
    w_lane_off = r_addr[LB-1:0];
    w_idx      = r_addr[ADDR_W-1:LB];
    w_low_mask = w_nbytes[LB-1:0] - 1'b1;
`ifdef DMU_ALIGN_CHECK_EN
    w_off      = w_lane_off;
    w_err      = (w_idx >= DEPTH_IDX) | (|(w_lane_off & w_low_mask));
`else
    w_off      = w_lane_off & ~w_low_mask;
    w_err      = (w_idx >= DEPTH_IDX);
`endif
    w_bmask    = lane_mask(w_nbytes) << w_off;
    w_wshift   = r_wdata << {w_off, 3'b000};
    w_word     = r_mem[w_idx[MEM_AW-1:0]];
    w_load     = extend(w_word >> {w_off, 3'b000}, w_nbytes, r_sext);
  end

  // Storage has no reset; a store is dropped if rst is high on its ACCESS edge.
  always_ff @(posedge clk) begin
    if (!rst && r_state == ACCESS && r_we && !w_err) begin
      for (int k = 0; k < NBYTES; k++)
        if (w_bmask[k]) r_mem[w_idx[MEM_AW-1:0]][8*k +: 8] <= w_wshift[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && req_valid) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_sext  <= req_sext;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_wb_en      <= 1'b0;
      r_wb_rd      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state <= ACCESS;
            r_wb_rd <= req_rd;
          end
        end
        ACCESS: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= w_err;
          r_resp_rdata <= (r_we || w_err) ? '0 : w_load;
          r_wb_en      <= ~r_we & ~w_err;
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_wb_en      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign wb_en      = r_wb_en;
  assign wb_rd      = r_wb_rd;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table, stall/reset sequences and
// randomized traffic checked against a byte-array reference model.
module tb_data_mem_unit;

`ifdef DMU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        wb_en;
  logic [4:0]  wb_rd;

  data_mem_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .wb_en(wb_en), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mb [256];

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sx;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vec [17];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference: memory as a flat byte array, 8 bytes per word, little-endian.
  task automatic model(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rdv, output logic er);
    int nb, off, base;
    nb  = 1 << sz;
    if (nb > 8) nb = 8;
    off = int'(a % 8);
    rdv = '0;
    er  = 1'b0;
    if ((a / 8) >= 64'd32) er = 1'b1;
    else if (ALIGN && (off % nb) != 0) er = 1'b1;
    else off = off - (off % nb);
    if (!er) begin
      base = int'(a / 8) * 8 + off;
      for (int b = 0; b < nb; b++) begin
        if (we) mb[base + b] = wd[8*b +: 8];
        else    rdv[8*b +: 8] = mb[base + b];
      end
      if (!we && sx && nb < 8 && rdv[8*nb-1])
        for (int b = nb; b < 8; b++) rdv[8*b +: 8] = 8'hFF;
    end
  endtask

  // One full transaction with resp_ready held high; starts and ends on a negedge in IDLE.
  task automatic txn(input logic we, input logic [1:0] sz, input logic sx,
                     input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd,
                     output logic [63:0] g_rdata, output logic g_err, output logic g_wb);
    int n;
    req_valid = 1'b1; req_we = we; req_size = sz; req_sext = sx;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd2);
    chk("wb_rd", 64'(wb_rd), 64'(rd));
    g_rdata = resp_rdata;
    g_err   = resp_err;
    g_wb    = wb_en;
    @(negedge clk);
    chk("after_handshake", {61'd0, req_ready, resp_valid, wb_en}, 64'b100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] g_rd, m_rd, s_rd;
    logic        g_err, g_wb, m_err, s_err;
    logic        r_we, r_sx;
    logic [1:0]  r_sz;
    logic [63:0] r_a, r_wd;
    logic [4:0]  r_tag;
    int          n;

    vec[0]  = '{1'b1, 2'd3, 1'b0, 64'h10,  64'h1122334455667788, 64'h0, 1'b0};
    vec[1]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h1122334455667788, 1'b0};
    vec[2]  = '{1'b1, 2'd0, 1'b0, 64'h13,  64'hFFFFFFFFFFFFFFAB, 64'h0, 1'b0};
    vec[3]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h11223344AB667788, 1'b0};
    vec[4]  = '{1'b0, 2'd0, 1'b1, 64'h13,  64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0};
    vec[5]  = '{1'b0, 2'd0, 1'b0, 64'h13,  64'h0, 64'h00000000000000AB, 1'b0};
    vec[6]  = '{1'b1, 2'd2, 1'b0, 64'h100, 64'h12345678, 64'h0, 1'b1};
    vec[7]  = '{1'b0, 2'd3, 1'b0, 64'h0,   64'h0, 64'hC0DE000000000000, 1'b0};
    vec[8]  = '{1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 64'h0, 1'b1};
    vec[9]  = '{1'b1, 2'd1, 1'b0, 64'h11,  64'hBEEF, 64'h0, ALIGN};
    vec[10] = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0,
                ALIGN ? 64'h11223344AB667788 : 64'h11223344AB66BEEF, 1'b0};
    vec[11] = '{1'b0, 2'd2, 1'b1, 64'h10,  64'h0,
                ALIGN ? 64'hFFFFFFFFAB667788 : 64'hFFFFFFFFAB66BEEF, 1'b0};
    vec[12] = '{1'b0, 2'd1, 1'b1, 64'h16,  64'h0, 64'h1122, 1'b0};
    vec[13] = '{1'b0, 2'd1, 1'b1, 64'h15,  64'h0, ALIGN ? 64'h0 : 64'h3344, ALIGN};
    vec[14] = '{1'b0, 2'd0, 1'b1, 64'h17,  64'h0, 64'h11, 1'b0};
    vec[15] = '{1'b0, 2'd2, 1'b0, 64'h14,  64'h0, 64'h11223344, 1'b0};
    vec[16] = '{1'b0, 2'd3, 1'b0, 64'h0C,  64'h0, ALIGN ? 64'h0 : 64'hC0DE000000000001, ALIGN};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    // Preload every word with a known pattern.
    for (int i = 0; i < 32; i++) begin
      txn(1'b1, 2'd3, 1'b0, 64'(i * 8), 64'hC0DE000000000000 | 64'(i), 5'(i), g_rd, g_err, g_wb);
      model(1'b1, 2'd3, 1'b0, 64'(i * 8), 64'hC0DE000000000000 | 64'(i), m_rd, m_err);
    end

    for (int i = 0; i < 17; i++) begin
      txn(vec[i].we, vec[i].sz, vec[i].sx, vec[i].addr, vec[i].wd, 5'(i + 3), g_rd, g_err, g_wb);
      model(vec[i].we, vec[i].sz, vec[i].sx, vec[i].addr, vec[i].wd, m_rd, m_err);
      chk($sformatf("vec%0d_rdata", i), g_rd, vec[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 64'(g_err), 64'(vec[i].exp_err));
      chk($sformatf("vec%0d_wb_en", i), 64'(g_wb), 64'(!vec[i].we && !vec[i].exp_err));
    end

    // Stall in RESP for 5 cycles while a competing request is offered.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_sext = 1'b0;
    req_addr = 64'h10; req_rd = 5'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("stall_latency", 64'(n), 64'd2);
    s_rd = resp_rdata; s_err = resp_err;
    chk("stall_rdata", s_rd, vec[10].exp_rd);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h0; req_wdata = 64'hDEAD; req_rd = 5'd9;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_ctl", c), {60'd0, resp_valid, req_ready, wb_en, resp_err},
          {60'd0, 1'b1, 1'b0, 1'b1, s_err});
      chk($sformatf("stall%0d_rdata", c), resp_rdata, s_rd);
      chk($sformatf("stall%0d_wb_rd", c), 64'(wb_rd), 64'd7);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", {62'd0, req_ready, resp_valid}, 64'b10);
    txn(1'b0, 2'd3, 1'b0, 64'h0, 64'h0, 5'd1, g_rd, g_err, g_wb);
    chk("ignored_store", g_rd, 64'hC0DE000000000000);

    // Reset asserted while a store sits in ACCESS.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = 64'h18;
    req_wdata = 64'hFF; req_rd = 5'd12;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_resp_err", 64'(resp_err), 64'd0);
    chk("abort_resp_rdata", resp_rdata, 64'd0);
    chk("abort_wb", {59'd0, wb_en, wb_rd}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {62'd0, req_ready, resp_valid}, 64'b10);
    txn(1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 5'd2, g_rd, g_err, g_wb);
    chk("abort_no_write", g_rd, 64'hC0DE000000000003);

    // Randomized traffic against the byte-array model.
    for (int i = 0; i < 300; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_sz  = 2'($urandom_range(0, 3));
      r_sx  = 1'($urandom_range(0, 1));
      r_a   = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 'h10F));
      r_wd  = {$urandom, $urandom};
      r_tag = 5'($urandom_range(0, 31));
      txn(r_we, r_sz, r_sx, r_a, r_wd, r_tag, g_rd, g_err, g_wb);
      model(r_we, r_sz, r_sx, r_a, r_wd, m_rd, m_err);
      chk($sformatf("rnd%0d_rdata", i), g_rd, m_rd);
      chk($sformatf("rnd%0d_err", i), 64'(g_err), 64'(m_err));
      chk($sformatf("rnd%0d_wb_en", i), 64'(g_wb), 64'(!r_we && !m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
